// File: rtl/uart_word_bridge.sv
// uart_word_bridge: packs UART RX bytes MSB-first into words for the crypter
// and serializes crypter words MSB-first back into the UART transmitter.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   rx_readable       UART RX has an unread byte on rx_data
//   rx_data           UART RX byte
//   rx_used_tick      pulse: byte consumed (clears rx_readable in the UART)
//   rx_discard_tick   pulse: partial word dropped after idle timeout
//   word_out          assembled word, first byte in the top 8 bits
//   word_valid        word_out valid (held until word_ready)
//   word_ready        crypter accepts word_out
//   word_in           word to transmit
//   word_in_valid     word_in valid
//   word_in_ready     bridge idle and able to take word_in
//   tx_start          pulse: start sending tx_data
//   tx_data           byte to transmit, held until the next tx_start
//   tx_busy           UART TX busy
//   tx_done_tick      UART TX byte complete
module uart_word_bridge #(
    parameter int WORD_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_readable,
    input  logic [7:0]                rx_data,
    output logic                      rx_used_tick,
    output logic                      rx_discard_tick,
    output logic [8*WORD_BYTES-1:0]   word_out,
    output logic                      word_valid,
    input  logic                      word_ready,
    input  logic [8*WORD_BYTES-1:0]   word_in,
    input  logic                      word_in_valid,
    output logic                      word_in_ready,
    output logic                      tx_start,
    output logic [7:0]                tx_data,
    input  logic                      tx_busy,
    input  logic                      tx_done_tick
);

    localparam int W  = 8 * WORD_BYTES;
    localparam int CW = $clog2(WORD_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] FULL     = CW'(WORD_BYTES);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {R_COLLECT, R_ACK, R_HOLD} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT} tx_state_t;

    rx_state_t     rx_state, rx_state_nx;
    logic [CW-1:0] rx_cnt, rx_cnt_nx;
    logic [TW-1:0] tmo_cnt, tmo_cnt_nx;
    logic [W-1:0]  rx_word_nx;
    logic          used_nx, discard_nx, valid_nx;

    tx_state_t     tx_state, tx_state_nx;
    logic [CW-1:0] tx_cnt, tx_cnt_nx;
    logic [W-1:0]  tx_shreg, tx_shreg_nx;
    logic [7:0]    tx_data_nx;
    logic          start_nx, in_ready_nx;

    // RX: the word register doubles as word_out; it cannot move while
    // word_valid is high because nothing is consumed in R_HOLD.
    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt;
        tmo_cnt_nx  = tmo_cnt;
        rx_word_nx  = word_out;
        used_nx     = 1'b0;
        discard_nx  = 1'b0;
        valid_nx    = word_valid;
        unique case (rx_state)
            R_COLLECT: begin
                if (rx_readable) begin
                    rx_word_nx  = {word_out[W-9:0], rx_data};
                    rx_cnt_nx   = rx_cnt + ONE;
                    used_nx     = 1'b1;
                    tmo_cnt_nx  = '0;
                    rx_state_nx = R_ACK;
                end else if (rx_cnt == '0) begin
                    tmo_cnt_nx = '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    rx_cnt_nx  = '0;
                    tmo_cnt_nx = '0;
                    discard_nx = 1'b1;
                end else begin
                    tmo_cnt_nx = tmo_cnt + 1'b1;
                end
            end
            // Dead cycle: the UART's flag is still high this cycle.
            R_ACK: begin
                if (rx_cnt == FULL) begin
                    rx_state_nx = R_HOLD;
                    valid_nx    = 1'b1;
                end else begin
                    rx_state_nx = R_COLLECT;
                end
            end
            R_HOLD: begin
                tmo_cnt_nx = '0;
                if (word_ready) begin
                    valid_nx    = 1'b0;
                    rx_cnt_nx   = '0;
                    rx_state_nx = R_COLLECT;
                end
            end
            default: rx_state_nx = R_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state        <= R_COLLECT;
            rx_cnt          <= '0;
            tmo_cnt         <= '0;
            word_out        <= '0;
            word_valid      <= 1'b0;
            rx_used_tick    <= 1'b0;
            rx_discard_tick <= 1'b0;
        end else begin
            rx_state        <= rx_state_nx;
            rx_cnt          <= rx_cnt_nx;
            tmo_cnt         <= tmo_cnt_nx;
            word_out        <= rx_word_nx;
            word_valid      <= valid_nx;
            rx_used_tick    <= used_nx;
            rx_discard_tick <= discard_nx;
        end
    end

    // TX: word_in_ready is high exactly while in T_IDLE.
    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_shreg_nx = tx_shreg;
        tx_data_nx  = tx_data;
        start_nx    = 1'b0;
        in_ready_nx = word_in_ready;
        unique case (tx_state)
            T_IDLE: begin
                if (word_in_valid) begin
                    tx_shreg_nx = word_in;
                    tx_cnt_nx   = FULL;
                    in_ready_nx = 1'b0;
                    tx_state_nx = T_START;
                end
            end
            T_START: begin
                if (!tx_busy) begin
                    tx_data_nx  = tx_shreg[W-1 -: 8];
                    start_nx    = 1'b1;
                    tx_state_nx = T_WAIT;
                end
            end
            T_WAIT: begin
                if (tx_done_tick) begin
                    tx_shreg_nx = {tx_shreg[W-9:0], 8'h00};
                    tx_cnt_nx   = tx_cnt - ONE;
                    if (tx_cnt == ONE) begin
                        tx_state_nx = T_IDLE;
                        in_ready_nx = 1'b1;
                    end else begin
                        tx_state_nx = T_START;
                    end
                end
            end
            default: tx_state_nx = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state      <= T_IDLE;
            tx_cnt        <= '0;
            tx_shreg      <= '0;
            tx_data       <= '0;
            tx_start      <= 1'b0;
            word_in_ready <= 1'b1;
        end else begin
            tx_state      <= tx_state_nx;
            tx_cnt        <= tx_cnt_nx;
            tx_shreg      <= tx_shreg_nx;
            tx_data       <= tx_data_nx;
            tx_start      <= start_nx;
            word_in_ready <= in_ready_nx;
        end
    end

endmodule
